store_write_buffer: RTL

Dcache-side responder for committed stores leaving the store queue. Each cycle it accepts up to `NUM_SQ_DCACHE` in-order `SQ_DCACHE_PACKET`s, returning a per-lane `dcache_accept`. Accepted stores are converted into word-aligned byte-enabled entries in a small FIFO, then drained one at a time to memory through the tagged bus handshake. Pending buffer contents are exposed to load FUs as a same-word conflict signal so loads never bypass buffered stores.

---
 rtl/store_write_buffer_pkg.sv | 49 ++++
 rtl/store_write_buffer_align.sv | 37 +++
 rtl/store_write_buffer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared types for the store write buffer: SQ->dcache packets, bus commands,
// buffer entry layout, drain FSM states and sizing constants.
package sys_defs;

   localparam int NUM_SQ_DCACHE = 2;
   localparam int SWB_DEPTH     = 4;
   localparam int SWB_IDX       = $clog2(SWB_DEPTH);
   localparam int NUM_FU_LOAD   = 2;

   typedef logic [31:0] ADDR;

   typedef enum logic [2:0] {
      MEM_BYTE  = 3'b000,
      MEM_HALF  = 3'b001,
      MEM_WORD  = 3'b010,
      MEM_BYTEU = 3'b100,
      MEM_HALFU = 3'b101
   } MEM_FUNC;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef struct packed {
      logic        valid;
      ADDR         addr;
      MEM_FUNC     sign_size;
      logic [31:0] data;
   } SQ_DCACHE_PACKET;

   typedef struct packed {
      logic        valid;
      logic [29:0] word_addr;
      logic [3:0]  be;
      logic [31:0] data;
   } SWB_ENTRY;

   typedef enum logic {
      SWB_IDLE  = 1'b0,
      SWB_ISSUE = 1'b1
   } SWB_STATE;

   function automatic logic [29:0] word_of(input ADDR a);
      return a[31:2];
   endfunction

endpackage

// File: rtl/store_write_buffer_align.sv
// swb_align: turns a store's size, low address bits and raw data into
// byte enables and byte-lane-positioned write data.
module swb_align
   import sys_defs::*;
(
   input  MEM_FUNC     i_sign_size,
   input  logic [1:0]  i_byte_ofs,
   input  logic [31:0] i_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_data
);

   always_comb begin
      o_be   = 4'b0000;
      o_data = 32'h0;
      case (i_sign_size)
         MEM_BYTE, MEM_BYTEU: begin
            o_be   = 4'b0001 << i_byte_ofs;
            o_data = 32'(i_data[7:0]) << {i_byte_ofs, 3'b000};
         end
         MEM_HALF, MEM_HALFU: begin
            // Halves are assumed aligned, so only addr[1] selects the lane pair.
            o_be   = i_byte_ofs[1] ? 4'b1100 : 4'b0011;
            o_data = i_byte_ofs[1] ? {i_data[15:0], 16'h0} : {16'h0, i_data[15:0]};
         end
         MEM_WORD: begin
            o_be   = 4'b1111;
            o_data = i_data;
         end
         default: begin
            o_be   = 4'b0000;
            o_data = 32'h0;
         end
      endcase
   end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: accepts committed stores, queues them word-aligned and
// drains one at a time over the tagged bus. Optional merging: SWB_COALESCE_EN.
module store_write_buffer
   import sys_defs::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  SQ_DCACHE_PACKET          sq_dcache_packet [NUM_SQ_DCACHE],
   output logic [NUM_SQ_DCACHE-1:0] dcache_accept,
   output BUS_COMMAND               proc2mem_command,
   output logic [31:0]              proc2mem_addr,
   output logic [31:0]              proc2mem_data,
   output logic [3:0]               proc2mem_be,
   input  logic [3:0]               mem2proc_transaction_tag,
   input  ADDR                      lq_addr [NUM_FU_LOAD],
   output logic [NUM_FU_LOAD-1:0]   lq_conflict,
   output logic                     swb_empty
);

   localparam int CNT_W = SWB_IDX + 1;

   SWB_ENTRY           r_entries [SWB_DEPTH];
   SWB_ENTRY           r_req;
   logic [SWB_IDX-1:0] r_head;
   logic [SWB_IDX-1:0] r_tail;
   logic [CNT_W-1:0]   r_count;
   SWB_STATE           r_state;
   SWB_STATE           w_state_next;

   SWB_ENTRY                 w_new_entry [NUM_SQ_DCACHE];
   logic [3:0]               w_lane_be   [NUM_SQ_DCACHE];
   logic [31:0]              w_lane_data [NUM_SQ_DCACHE];
   logic [SWB_IDX-1:0]       w_slot      [NUM_SQ_DCACHE];
   logic [NUM_SQ_DCACHE-1:0] w_take;
   logic [CNT_W-1:0]         w_num_take;
   logic [CNT_W-1:0]         w_free;
   logic                     w_pop;
   logic                     w_tag_hit;

   assign w_free    = CNT_W'(SWB_DEPTH) - r_count;
   assign w_tag_hit = |mem2proc_transaction_tag;
   assign swb_empty = (r_state == SWB_IDLE) && (r_count == '0);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SQ_DCACHE; gi++) begin : g_lane
         swb_align u_align (
            .i_sign_size (sq_dcache_packet[gi].sign_size),
            .i_byte_ofs  (sq_dcache_packet[gi].addr[1:0]),
            .i_data      (sq_dcache_packet[gi].data),
            .o_be        (w_lane_be[gi]),
            .o_data      (w_lane_data[gi])
         );
         assign w_new_entry[gi] = '{valid:     1'b1,
                                    word_addr: word_of(sq_dcache_packet[gi].addr),
                                    be:        w_lane_be[gi],
                                    data:      w_lane_data[gi]};
      end
   endgenerate

`ifdef SWB_COALESCE_EN
   logic [NUM_SQ_DCACHE-1:0] w_merge;
   logic [SWB_IDX-1:0]       w_young;
   logic                     w_merge_ok;
   SWB_ENTRY                 w_merged;

   // The youngest entry is off limits when it is the head leaving this edge.
   assign w_young    = r_tail - SWB_IDX'(1);
   assign w_merge_ok = (r_count != '0) && !(w_pop && (r_count == CNT_W'(1)));

   always_comb begin : p_merge
      w_merged = r_entries[w_young];
      for (int i = 0; i < NUM_SQ_DCACHE; i++) begin
         if (w_merge[i]) begin
            w_merged.be = w_merged.be | w_lane_be[i];
            for (int b = 0; b < 4; b++) begin
               if (w_lane_be[i][b]) begin
                  w_merged.data[8*b +: 8] = w_lane_data[i][8*b +: 8];
               end
            end
         end
      end
   end

   assign dcache_accept = reset ? (w_take | w_merge) : '0;
`else
   assign dcache_accept = reset ? w_take : '0;
`endif

   // In-order acceptance: the first valid lane that cannot be placed blocks all later ones.
   always_comb begin : p_accept
      logic             blocked;
      logic [CNT_W-1:0] n_take;
      blocked = 1'b0;
      n_take  = '0;
      w_take  = '0;
`ifdef SWB_COALESCE_EN
      w_merge = '0;
`endif
      for (int i = 0; i < NUM_SQ_DCACHE; i++) begin
         w_slot[i] = r_tail + n_take[SWB_IDX-1:0];
         if (sq_dcache_packet[i].valid && !blocked) begin
`ifdef SWB_COALESCE_EN
            if (w_merge_ok && (n_take == '0) &&
                (word_of(sq_dcache_packet[i].addr) == r_entries[w_young].word_addr)) begin
               w_merge[i] = 1'b1;
            end else
`endif
            if (w_free > n_take) begin
               w_take[i] = 1'b1;
               n_take    = n_take + CNT_W'(1);
            end else begin
               blocked = 1'b1;
            end
         end
      end
      w_num_take = n_take;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= SWB_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin : p_fsm
      w_state_next     = r_state;
      w_pop            = 1'b0;
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = 32'h0;
      proc2mem_data    = 32'h0;
      proc2mem_be      = 4'b0000;
      case (r_state)
         SWB_IDLE: begin
            if (r_count != '0) begin
               w_pop        = 1'b1;
               w_state_next = SWB_ISSUE;
            end
         end
         SWB_ISSUE: begin
            proc2mem_command = BUS_STORE;
            proc2mem_addr    = {r_req.word_addr, 2'b00};
            proc2mem_data    = r_req.data;
            proc2mem_be      = r_req.be;
            if (w_tag_hit) begin
               if (r_count != '0) begin
                  w_pop = 1'b1;
               end else begin
                  w_state_next = SWB_IDLE;
               end
            end
         end
         default: w_state_next = SWB_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_req   <= '0;
         for (int k = 0; k < SWB_DEPTH; k++) begin
            r_entries[k] <= '0;
         end
      end else begin
         if (w_pop) begin
            r_req                  <= r_entries[r_head];
            r_entries[r_head].valid <= 1'b0;
            r_head                 <= r_head + SWB_IDX'(1);
         end else if ((r_state == SWB_ISSUE) && w_tag_hit) begin
            r_req <= '0;
         end
`ifdef SWB_COALESCE_EN
         if (|w_merge) begin
            r_entries[w_young] <= w_merged;
         end
`endif
         for (int i = 0; i < NUM_SQ_DCACHE; i++) begin
            if (w_take[i]) begin
               r_entries[w_slot[i]] <= w_new_entry[i];
            end
         end
         r_tail  <= r_tail + w_num_take[SWB_IDX-1:0];
         r_count <= r_count + w_num_take - CNT_W'(w_pop);
      end
   end

   // Loads must not pass any queued or in-flight store to the same word.
   generate
      for (gi = 0; gi < NUM_FU_LOAD; gi++) begin : g_conf
         logic [SWB_DEPTH-1:0] w_hit;
         genvar gj;
         for (gj = 0; gj < SWB_DEPTH; gj++) begin : g_ent
            assign w_hit[gj] = r_entries[gj].valid &&
                               (r_entries[gj].word_addr == word_of(lq_addr[gi]));
         end
         assign lq_conflict[gi] = (|w_hit) ||
                                  ((r_state == SWB_ISSUE) && (r_req.word_addr == word_of(lq_addr[gi])));
      end
   endgenerate

endmodule
